keypad_capture_top: RTL and testbench
=====================================

// Module: keypad_capture_top
// PURPOSE
//  - Top level for the 4-key input path (27 MHz board clock).
//  - Synchronizes 4 active-low key lines and debounces them with a clock-divider sample tick.
//  - Encodes a single pressed key to a 4-bit code.
//  - Flags each newly accepted key with a one-clock data_available strobe.
// PARAMETERS
//  DIV_COUNT        270  clk cycles per debounce sample tick (10 us at 27 MHz)
//  DEBOUNCE_SAMPLES 4    consecutive equal tick samples required to accept a new key vector
// PORTS
//  clk            in   1  system clock, 27 MHz, rising edge
//  rst            in   1  asynchronous reset, active-low
//  key_in         in   4  raw key lines, active-low (bit i low = key i pressed), asynchronous
//  data_available out  1  one-clk strobe: new key accepted, dato_o valid
//  dato_o         out  4  code of last accepted key
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst=0):
//   - data_available=0, dato_o=4'd0.
//   - Divider counter=0; synchronizer, sample and debounced vectors=4'b1111 (released).
//   - Stable count=0.
//  Synchronizer: 2-FF on each key_in bit. Output is sync_key.
//  Divider:
//   - Counter 0..DIV_COUNT-1, wraps to 0.
//   - tick=1 for exactly one clk when counter==DIV_COUNT-1.
//  Debounce (updates on tick only):
//   - sync_key!=last sample: store sample, clear stable count.
//   - Otherwise: increment stable count, saturating at DEBOUNCE_SAMPLES-1.
//   - When stable count reaches DEBOUNCE_SAMPLES-1: deb_key <= sample.
//   - Glitches shorter than one tick period never reach deb_key.
//  Encoder (valid only when exactly one bit of deb_key is 0):
//   - 1110->0, 1101->1, 1011->2, 0111->3; dato_o[3:2]=0.
//   - 1111 (released) is not valid.
//   - Any pattern with two or more low bits is not valid.
//  Event:
//   - Clk after deb_key changes to a valid pattern: data_available=1 for exactly one clk.
//   - Same edge: dato_o <= code.
//   - Key-to-key change without release (1110->1101) is a new event.
//   - Change to release or to an invalid pattern: no strobe, dato_o holds.
//  Latency: press to strobe <= (DEBOUNCE_SAMPLES+1)*DIV_COUNT+4 clk (~1354 clk, ~50 us).
//  Holding a key: single strobe only, no auto-repeat.
//  Reset mid-operation:
//   - All state returns to reset values.
//   - A key still held after reset release is re-detected as a new event after full debounce latency.
//  Simultaneous tick and reset: reset wins.
// CONFIGURATION
//  KEYPAD_PRIORITY_EN defined:
//   - Patterns with several low bits are valid; code = lowest low bit index (0000->0, 0011->2).
//   - Event still fires only on a change of the encoded code, or a change from released.
//  KEYPAD_PRIORITY_EN undefined: multi-key patterns ignored as above.
// TESTING
//  1. rst=0 then 1, key_in=1111 held 200 us -> data_available never 1, dato_o=0.
//  2. key_in=1110 -> within 60 us a single 1-clk data_available pulse with dato_o=0.
//  3. Every 300 us key_in=1101, 1011, 0111 with no release -> three strobes, dato_o=1,2,3.
//  4. Pulse rst low 37 ns while 0111 held -> data_available=0 and dato_o=0 immediately;
//     one strobe with dato_o=3 within 60 us after release of reset.
//  5. 1011 with a 1111 glitch of 2 us every 5 us -> one strobe only, dato_o=2.
//  6. key_in=0000 -> no strobe; with KEYPAD_PRIORITY_EN -> strobe, dato_o=0.

Source files
------------

// File: rtl/keypad_capture_top.sv
// keypad_capture_top: 4-key input path. Synchronizes and debounces four
// active-low key lines on a divided sample tick, encodes a single pressed key
// and strobes data_available for one clock on each newly accepted key.
// Optional build macro: KEYPAD_PRIORITY_EN (multi-key patterns resolve to the
// lowest pressed key index instead of being ignored).
module keypad_capture_top #(
  parameter int unsigned DIV_COUNT        = 270,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic       data_available,
  output logic [3:0] dato_o
);

  localparam int unsigned KEY_W = 4;
  localparam int unsigned DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned STB_W = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(DEBOUNCE_SAMPLES - 1);

  logic [KEY_W-1:0] key_meta;
  logic [KEY_W-1:0] sync_key;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [KEY_W-1:0] sample_key;
  logic [STB_W-1:0] stable_cnt;
  logic [STB_W-1:0] stable_nxt_c;
  logic [KEY_W-1:0] deb_key;
  logic [KEY_W-1:0] deb_prev;
  logic [2:0]       enc_cur_c;
  logic [2:0]       enc_prev_c;
  logic             new_evt_c;

  // Returns {valid, code[1:0]} for a debounced key vector.
  function automatic logic [2:0] encode(input logic [KEY_W-1:0] v);
    logic [2:0] r;
    r = '0;
`ifdef KEYPAD_PRIORITY_EN
    // Descending scan so the lowest pressed index wins.
    for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
      if (!v[i]) r = {1'b1, 2'(i)};
    end
`else
    case (v)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
`endif
    return r;
  endfunction

  // Two-flop synchronizer on the asynchronous key lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= '1;
      sync_key <= '1;
    end else begin
      key_meta <= key_in;
      sync_key <= key_meta;
    end
  end

  // Sample-tick divider, one tick per DIV_COUNT clocks.
  assign tick_c = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Saturating next value of the stable-sample count.
  always_comb begin
    stable_nxt_c = stable_cnt;
    if (stable_cnt != STB_LAST) stable_nxt_c = stable_cnt + STB_W'(1);
  end

  // Debounce: accept a vector once it has been sampled equal on enough ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_key <= '1;
      stable_cnt <= '0;
      deb_key    <= '1;
    end else if (tick_c) begin
      if (sync_key != sample_key) begin
        sample_key <= sync_key;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_nxt_c;
        if (stable_nxt_c == STB_LAST) deb_key <= sample_key;
      end
    end
  end

  // Event detection on a change of the debounced vector.
  always_comb begin
    enc_cur_c  = encode(deb_key);
    enc_prev_c = encode(deb_prev);
`ifdef KEYPAD_PRIORITY_EN
    new_evt_c  = enc_cur_c[2] && (!enc_prev_c[2] || (enc_cur_c[1:0] != enc_prev_c[1:0]));
`else
    new_evt_c  = enc_cur_c[2] && (deb_key != deb_prev);
`endif
  end

  // Registered strobe and held key code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev       <= '1;
      data_available <= 1'b0;
      dato_o         <= '0;
    end else begin
      deb_prev       <= deb_key;
      data_available <= new_evt_c;
      if (new_evt_c) dato_o <= {2'b00, enc_cur_c[1:0]};
    end
  end

endmodule

// File: tb/tb_keypad_capture_top.sv
// Testbench for keypad_capture_top: directed scenarios plus random key
// activity, checked cycle by cycle against a tick-history reference model.
`timescale 1ns/100ps
module tb_keypad_capture_top;

  localparam int unsigned DIV   = 270;
  localparam int unsigned NSMP  = 4;
  localparam int unsigned LAT_MAX = (NSMP + 1) * DIV + 4;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic       data_available;
  logic [3:0] dato_o;

  int n_checks;
  int n_errors;
  int unsigned cyc;

  keypad_capture_top #(.DIV_COUNT(DIV), .DEBOUNCE_SAMPLES(NSMP)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_in         (key_in),
    .data_available (data_available),
    .dato_o         (dato_o)
  );

  initial clk = 1'b0;
  always #18.5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int zeros(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic int lowest_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) return i;
    return -1;
  endfunction

  // Does the debounced vector moving from prev to cur produce a key event?
  function automatic bit is_event(input logic [3:0] prev, input logic [3:0] cur);
`ifdef KEYPAD_PRIORITY_EN
    if (zeros(cur) == 0) return 1'b0;
    return (prev == 4'hF) || (lowest_zero(prev) != lowest_zero(cur));
`else
    return (prev != cur) && (zeros(cur) == 1);
`endif
  endfunction

  logic [3:0]  m_raw_q[$];   // key_in seen at the last two edges (sync delay)
  logic [3:0]  m_hist[$];    // key values seen on the last NSMP sample ticks
  logic [3:0]  m_deb;
  logic [3:0]  m_seen;
  logic [3:0]  pend_code;
  logic [3:0]  exp_dato;
  logic        exp_da;
  bit          pend;
  bit          all_eq;
  int unsigned m_edge;
  int unsigned m_tick_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_raw_q = {};
      m_raw_q.push_back(4'hF);
      m_raw_q.push_back(4'hF);
      m_hist = {};
      for (int i = 0; i < int'(NSMP); i++) m_hist.push_back(4'hF);
      m_deb    = 4'hF;
      exp_da   = 1'b0;
      exp_dato = 4'h0;
      pend     = 1'b0;
      m_edge   = 0;
    end else begin
      m_edge++;
      exp_da = pend;
      if (pend) exp_dato = pend_code;
      pend = 1'b0;
      m_seen = m_raw_q.pop_front();
      m_raw_q.push_back(key_in);
      if (m_edge % DIV == 0) begin
        m_tick_cnt++;
        m_hist.push_back(m_seen);
        void'(m_hist.pop_front());
        all_eq = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
        if (all_eq && (m_hist[0] != m_deb)) begin
          if (is_event(m_deb, m_hist[0])) begin
            pend      = 1'b1;
            pend_code = 4'(lowest_zero(m_hist[0]));
          end
          m_deb = m_hist[0];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [3:0]  stb_codes[$];
  int unsigned stb_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_available === 1'b1) begin
      stb_codes.push_back(dato_o);
      stb_cyc.push_back(cyc);
    end
    check("cyc_da", 32'(data_available), 32'(exp_da));
    check("cyc_dato", 32'(dato_o), 32'(exp_dato));
  end

  function automatic logic [31:0] code_at(input int idx);
    if (idx < stb_codes.size()) return 32'(stb_codes[idx]);
    return 32'hDEAD;
  endfunction

  task automatic wait_us(input int n);
    #(n * 1000);
  endtask

  task automatic clear_strobes();
    stb_codes.delete();
    stb_cyc.delete();
  endtask

  task automatic reset_pulse(input int low_ns);
    rst = 1'b0;
    #1;
    check("rst_da", 32'(data_available), 32'd0);
    check("rst_dato", 32'(dato_o), 32'd0);
    #(low_ns - 1);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int unsigned press_cyc;
  int unsigned t0;
  int          dur;
  int          sel;
  bit          lat_ok;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    m_tick_cnt = 0;
    rst        = 1'b0;
    key_in     = 4'hF;
    #100;
    check("reset_da", 32'(data_available), 32'd0);
    check("reset_dato", 32'(dato_o), 32'd0);
    rst = 1'b1;

    // Released keys for 200 us: nothing happens.
    clear_strobes();
    wait_us(200);
    check("idle_strobes", 32'(stb_codes.size()), 32'd0);
    check("idle_dato", 32'(dato_o), 32'd0);

    // Key 0 press: one strobe, code 0, within the latency bound.
    clear_strobes();
    key_in    = 4'b1110;
    press_cyc = cyc;
    wait_us(60);
    check("k0_strobes", 32'(stb_codes.size()), 32'd1);
    check("k0_code", code_at(0), 32'd0);
    lat_ok = (stb_cyc.size() > 0) && ((stb_cyc[0] - press_cyc) <= LAT_MAX);
    check("k0_latency_ok", 32'(lat_ok), 32'd1);

    // Key-to-key changes without release, each held 300 us.
    clear_strobes();
    key_in = 4'b1101; wait_us(300);
    key_in = 4'b1011; wait_us(300);
    key_in = 4'b0111; wait_us(300);
    check("k2k_strobes", 32'(stb_codes.size()), 32'd3);
    check("k2k_code1", code_at(0), 32'd1);
    check("k2k_code2", code_at(1), 32'd2);
    check("k2k_code3", code_at(2), 32'd3);

    // Short reset pulse while key 3 is held: re-detected after release.
    reset_pulse(37);
    clear_strobes();
    wait_us(60);
    check("rst_held_strobes", 32'(stb_codes.size()), 32'd1);
    check("rst_held_code", code_at(0), 32'd3);

    // Key 2 with 2 us release glitches every 5 us, placed between sample ticks.
    clear_strobes();
    t0 = m_tick_cnt;
    for (int i = 0; i < 400 && m_tick_cnt == t0; i++) @(negedge clk);
    check("tick_seen", 32'(m_tick_cnt != t0), 32'd1);
    #500 key_in = 4'b1011;
    #1500;
    for (int i = 0; i < 40; i++) begin
      key_in = 4'b1111; #2000;
      key_in = 4'b1011; #3000;
    end
    check("glitch_strobes", 32'(stb_codes.size()), 32'd1);
    check("glitch_code", code_at(0), 32'd2);

    // All keys pressed at once.
    clear_strobes();
    key_in = 4'b0000;
    wait_us(100);
`ifdef KEYPAD_PRIORITY_EN
    check("multi_strobes", 32'(stb_codes.size()), 32'd1);
    check("multi_code", code_at(0), 32'd0);
`else
    check("multi_strobes", 32'(stb_codes.size()), 32'd0);
    check("multi_dato_hold", 32'(dato_o), 32'd2);
`endif

    // Release: no strobe, code holds.
    clear_strobes();
    key_in = 4'b1111;
    wait_us(100);
    check("release_strobes", 32'(stb_codes.size()), 32'd0);

    // Random key activity, including short holds and occasional resets.
    for (int s = 0; s < 40; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      key_in = ~(4'b0001 << $urandom_range(0, 3));
      else if (sel <= 7) key_in = 4'hF;
      else               key_in = 4'($urandom_range(0, 15));
      dur = int'($urandom_range(1000, 45000));
      #(dur);
      if ($urandom_range(0, 14) == 0) reset_pulse(int'($urandom_range(5, 120)));
    end
    key_in = 4'hF;
    wait_us(60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
